nvram_ioctl_bridge: RTL and testbench

- Connects the hps_io ioctl channel to the game's non-volatile RAM (EAROM shadow for high scores and settings).
- Serves host uploads (save) as the read responder, with an ioctl_wait handshake.
- Applies host downloads (restore) as single-cycle RAM writes.
- Drives the RAM's second port, holds the CPU off the NVRAM during transfers, and raises a dirty flag for autosave.

---
 rtl/nvram_ioctl_bridge.sv | 134 +++++++++++++
 tb/tb_nvram_ioctl_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_ioctl_bridge.sv
// Bridges the hps_io ioctl channel to NVRAM port B: upload reads with a
// wait handshake, download writes as one-cycle pulses, a CPU hold-off
// during transfers and a dirty flag for autosave.
module nvram_ioctl_bridge #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NV_INDEX = 4
) (
  input  logic              clk_i,
  input  logic              btnCpuReset,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] nv_addr,
  output logic [7:0]        nv_dout,
  output logic              nv_we,
  input  logic [7:0]        nv_q,
  input  logic              cpu_nv_we,
  output logic              cpu_hold,
  output logic              nv_dirty
);

  localparam int unsigned DATA_W = 8;
  localparam logic [DATA_W-1:0] DIN_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   nv_addr_q, nv_addr_d;
  logic [DATA_W-1:0]   nv_dout_q, nv_dout_d;
  logic                nv_we_q, nv_we_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rng_q, rng_d;
  logic                hold_q, hold_d;
  logic                sess_q, sess_d;
  logic                clr_q, clr_d;
  logic                dirty_q, dirty_d;

  logic                sel_up, sel_dn, in_rng, rd_accept, dirty_set;

  // Channel selection and address range decode.
  always_comb begin
    sel_up    = ioctl_upload && (ioctl_index == 8'(NV_INDEX));
    sel_dn    = ioctl_download && (ioctl_index == 8'(NV_INDEX)) && !ioctl_upload;
    in_rng    = (ioctl_addr[24:ADDR_W] == '0);
    rd_accept = (state_q == IDLE) && ioctl_rd && sel_up;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    nv_addr_d = nv_addr_q;
    nv_dout_d = nv_dout_q;
    nv_we_d   = 1'b0;
    din_d     = din_q;
    rng_d     = rng_q;

    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          nv_addr_d = ioctl_addr[ADDR_W-1:0];
          rng_d     = in_rng;
          state_d   = RD_ADDR;
        end else if (ioctl_wr && sel_dn && in_rng) begin
          nv_addr_d = ioctl_addr[ADDR_W-1:0];
          nv_dout_d = ioctl_dout;
          nv_we_d   = 1'b1;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        din_d   = rng_q ? nv_q : DIN_IDLE;
        state_d = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Hold the CPU off while a session is open or a read is still draining.
    sess_d    = sel_up || sel_dn;
    hold_d    = sess_d || (state_q != IDLE);
    clr_d     = sess_q && !sess_d;
    // CPU write wins over the session-end clear.
    dirty_set = cpu_nv_we && !hold_q;
    dirty_d   = dirty_set || (dirty_q && !clr_q);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q   <= IDLE;
      nv_addr_q <= '0;
      nv_dout_q <= '0;
      nv_we_q   <= 1'b0;
      din_q     <= DIN_IDLE;
      rng_q     <= 1'b0;
      hold_q    <= 1'b0;
      sess_q    <= 1'b0;
      clr_q     <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nv_addr_q <= nv_addr_d;
      nv_dout_q <= nv_dout_d;
      nv_we_q   <= nv_we_d;
      din_q     <= din_d;
      rng_q     <= rng_d;
      hold_q    <= hold_d;
      sess_q    <= sess_d;
      clr_q     <= clr_d;
      dirty_q   <= dirty_d;
    end
  end

  // Wait rises in the strobe cycle itself and is forced low during reset.
  assign ioctl_wait = btnCpuReset && (rd_accept || (state_q != IDLE));
  assign ioctl_din  = din_q;
  assign nv_addr    = nv_addr_q;
  assign nv_dout    = nv_dout_q;
  assign nv_we      = nv_we_q;
  assign cpu_hold   = hold_q;
  assign nv_dirty   = dirty_q;

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Directed bench for nvram_ioctl_bridge with a synchronous-read RAM model
// on port B and scoreboard queues for upload data and download writes.
module tb_nvram_ioctl_bridge;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              btnCpuReset = 1'b0;
  logic              ioctl_upload = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic [24:0]       ioctl_addr = 25'd0;
  logic              ioctl_rd = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [7:0]        ioctl_dout = 8'd0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] nv_addr;
  logic [7:0]        nv_dout;
  logic              nv_we;
  logic [7:0]        nv_q = 8'd0;
  logic              cpu_nv_we = 1'b0;
  logic              cpu_hold;
  logic              nv_dirty;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [7:0]  rd_exp_q[$];
  logic [13:0] wr_exp_q[$];

  // RAM model: port B plus a bench-only preload port.
  logic [7:0]        mem [DEPTH];
  logic              tb_we = 1'b0;
  logic [ADDR_W-1:0] tb_a = '0;
  logic [7:0]        tb_d = 8'd0;

  always #5 clk_i = ~clk_i;

  nvram_ioctl_bridge #(.ADDR_W(6), .NV_INDEX(4)) dut (
    .clk_i(clk_i), .btnCpuReset(btnCpuReset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .nv_addr(nv_addr), .nv_dout(nv_dout), .nv_we(nv_we), .nv_q(nv_q),
    .cpu_nv_we(cpu_nv_we), .cpu_hold(cpu_hold), .nv_dirty(nv_dirty)
  );

  always @(posedge clk_i) begin
    if (tb_we) mem[tb_a] <= tb_d;
    if (nv_we) mem[nv_addr] <= nv_dout;
    nv_q <= mem[nv_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every nv_we pulse must match the oldest outstanding download write.
  always @(negedge clk_i) begin
    if (nv_we) begin
      we_count++;
      if (wr_exp_q.size() == 0) begin
        check("nv_we_unexpected", 32'(nv_we), 32'd0);
      end else begin
        logic [13:0] e;
        e = wr_exp_q.pop_front();
        check("nv_addr", 32'(nv_addr), 32'(e[13:8]));
        check("nv_dout", 32'(nv_dout), 32'(e[7:0]));
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one upload read and measure the wait window and returned byte.
  task automatic do_read(input logic [24:0] a, input logic [7:0] exp);
    int n;
    int k;
    logic [7:0] din_t3;
    logic [7:0] e;
    rd_exp_q.push_back(exp);
    din_t3 = 8'h00;
    cycle(); ioctl_addr = a; ioctl_rd = 1'b1;
    @(negedge clk_i);
    check("rd_wait_t0", 32'(ioctl_wait), 32'd1);
    n = 1;
    k = 1;
    cycle(); ioctl_rd = 1'b0;
    @(negedge clk_i);
    while (ioctl_wait && k < 16) begin
      n++;
      if (k == 3) din_t3 = ioctl_din;
      k++;
      @(negedge clk_i);
    end
    e = rd_exp_q.pop_front();
    check("rd_wait_cycles", 32'(n), 32'd4);
    check("rd_din_t3", 32'(din_t3), 32'(e));
    check("rd_din_t4", 32'(ioctl_din), 32'(e));
  endtask

  task automatic cpu_pulse();
    cycle(); cpu_nv_we = 1'b1;
    cycle(); cpu_nv_we = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    // Reset with RAM preload.
    cycle(); tb_we = 1'b1; tb_a = 6'd5; tb_d = 8'hA7;
    cycle(); tb_we = 1'b0;
    @(negedge clk_i);
    check("rst_din", 32'(ioctl_din), 32'hFF);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_nv_we", 32'(nv_we), 32'd0);
    check("rst_nv_addr", 32'(nv_addr), 32'd0);
    check("rst_nv_dout", 32'(nv_dout), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_dirty", 32'(nv_dirty), 32'd0);
    btnCpuReset = 1'b1;

    // CPU write while not held sets dirty.
    cpu_pulse();
    check("dirty_cpu_set", 32'(nv_dirty), 32'd1);

    // Upload on a foreign index: read strobe ignored, no hold.
    cycle(); ioctl_upload = 1'b1; ioctl_index = 8'd3; ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    @(negedge clk_i);
    check("rd_foreign_wait", 32'(ioctl_wait), 32'd0);
    cycle(); ioctl_rd = 1'b0;
    @(negedge clk_i);
    check("rd_foreign_wait2", 32'(ioctl_wait), 32'd0);
    check("rd_foreign_hold", 32'(cpu_hold), 32'd0);

    // Matching upload session: hold rises one cycle later.
    cycle(); ioctl_index = 8'd4;
    @(negedge clk_i);
    check("hold_rise_t0", 32'(cpu_hold), 32'd0);
    cycle();
    @(negedge clk_i);
    check("hold_rise_t1", 32'(cpu_hold), 32'd1);
    do_read(25'd5, 8'hA7);
    do_read(25'd64, 8'hFF);

    // End upload with a CPU write in the clear cycle: set wins.
    cycle(); ioctl_upload = 1'b0;
    cycle(); cpu_nv_we = 1'b1;
    cycle(); cpu_nv_we = 1'b0;
    @(negedge clk_i);
    check("dirty_set_wins", 32'(nv_dirty), 32'd1);
    check("hold_fall", 32'(cpu_hold), 32'd0);

    // Upload end without CPU write clears dirty.
    cycle(); ioctl_upload = 1'b1;
    repeat (3) cycle();
    ioctl_upload = 1'b0;
    repeat (3) cycle();
    @(negedge clk_i);
    check("dirty_clear", 32'(nv_dirty), 32'd0);

    // CPU write while held is ignored.
    cycle(); ioctl_upload = 1'b1;
    repeat (2) cycle();
    cpu_pulse();
    check("dirty_held_cpu", 32'(nv_dirty), 32'd0);
    cycle(); ioctl_upload = 1'b0;
    repeat (3) cycle();

    // Restore: 64 back-to-back writes.
    cycle(); ioctl_download = 1'b1; ioctl_index = 8'd4;
    for (int i = 0; i < 64; i++) begin
      cycle();
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i) ^ 8'h5A;
      wr_exp_q.push_back({6'(i), 8'(i) ^ 8'h5A});
      @(negedge clk_i);
      check("dn_we_pipe", 32'(nv_we), (i > 0) ? 32'd1 : 32'd0);
      check("dn_wait", 32'(ioctl_wait), 32'd0);
    end
    cycle(); ioctl_wr = 1'b1; ioctl_addr = 25'd64; ioctl_dout = 8'h33;
    @(negedge clk_i);
    check("dn_we_last", 32'(nv_we), 32'd1);
    cycle(); ioctl_wr = 1'b0;
    @(negedge clk_i);
    check("dn_we_oor", 32'(nv_we), 32'd0);
    check("dn_we_count", 32'(we_count), 32'd64);
    check("dn_hold", 32'(cpu_hold), 32'd1);
    cycle(); ioctl_download = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 64; i++) check("ram_readback", 32'(mem[i]), 32'(8'(i) ^ 8'h5A));

    // ROM loads on other indices leave the NVRAM alone.
    cpu_pulse();
    check("dirty_pre_rom", 32'(nv_dirty), 32'd1);
    for (int j = 0; j < 2; j++) begin
      cycle(); ioctl_download = 1'b1; ioctl_index = (j == 0) ? 8'd3 : 8'd0;
      for (int i = 0; i < 10; i++) begin
        cycle(); ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'hC3;
        cycle(); ioctl_wr = 1'b0;
        @(negedge clk_i);
        check("rom_we", 32'(nv_we), 32'd0);
        check("rom_hold", 32'(cpu_hold), 32'd0);
      end
      cycle(); ioctl_download = 1'b0;
      repeat (2) cycle();
      @(negedge clk_i);
      check("rom_dirty", 32'(nv_dirty), 32'd1);
    end
    check("rom_we_count", 32'(we_count), 32'd64);

    // Reset asserted in the RD_DATA cycle.
    cycle(); ioctl_upload = 1'b1; ioctl_index = 8'd4;
    repeat (2) cycle();
    ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    cycle(); ioctl_rd = 1'b0;
    cycle();
    #2 btnCpuReset = 1'b0;
    #1;
    check("rst_mid_wait", 32'(ioctl_wait), 32'd0);
    check("rst_mid_din", 32'(ioctl_din), 32'hFF);
    check("rst_mid_we", 32'(nv_we), 32'd0);
    @(negedge clk_i);
    btnCpuReset = 1'b1;
    repeat (2) cycle();
    do_read(25'd5, 8'h5F);
    cycle(); ioctl_upload = 1'b0;
    repeat (3) cycle();
    check("final_sb_empty", 32'(wr_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
